// File: rtl/backlight_frame_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : backlight_frame_sched_if
// Purpose  : Bundles the zone-write side and the LED-driver side of the
//            backlight frame scheduler.
// Ports    : zone_valid/zone_idx/zone_gray - shadow-buffer write port
//            frame_done                    - shadow frame complete pulse
//            mode/bright                   - output mode and global brightness
//            sdbpflag/wten/wtaddr/wtdina   - LED driver frame flag and words
//            swap_pulse/idx_err            - buffer-swap pulse, sticky error
// Revision : 1.0 - initial release
// ============================================================================
interface backlight_frame_sched_if #(
    parameter int ADDR_W = 10,
    parameter int GRAY_W = 8,
    parameter int OUT_W  = 16
);
    logic              zone_valid;
    logic [ADDR_W-1:0] zone_idx;
    logic [GRAY_W-1:0] zone_gray;
    logic              frame_done;
    logic [2:0]        mode;
    logic [7:0]        bright;

    logic              sdbpflag;
    logic              wten;
    logic [ADDR_W-1:0] wtaddr;
    logic [OUT_W-1:0]  wtdina;
    logic              swap_pulse;
    logic              idx_err;

    // Host / zone-data producer side
    modport master (
        output zone_valid, zone_idx, zone_gray, frame_done, mode, bright,
        input  sdbpflag, wten, wtaddr, wtdina, swap_pulse, idx_err
    );

    // Scheduler side
    modport slave (
        input  zone_valid, zone_idx, zone_gray, frame_done, mode, bright,
        output sdbpflag, wten, wtaddr, wtdina, swap_pulse, idx_err
    );
endinterface
`default_nettype wire

// File: rtl/backlight_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : backlight_frame_sched
// Purpose  : Double-buffered backlight zone scheduler. Zone grays are written
//            into a shadow buffer, committed to the active buffer at the start
//            of a refresh period, and scanned out once per period to an LED
//            driver as (address, data, strobe) words.
// Ports    : clk  - sole clock
//            rst  - synchronous active-high reset
//            bus  - slave side of backlight_frame_sched_if
// Revision : 1.0 - initial release
// ============================================================================
module backlight_frame_sched #(
    parameter int N_ZONES    = 360,
    parameter int ADDR_W     = 10,
    parameter int GRAY_W     = 8,
    parameter int OUT_W      = 16,
    parameter int COLS       = 24,
    parameter int CFG_WAIT   = 2500,
    parameter int PERIOD     = 420000,
    parameter int FLAG_LEN   = 30,
    parameter int SCAN_START = 4,
    parameter int RUN_HOLD   = 20
) (
    input  wire logic              clk,
    input  wire logic              rst,
    backlight_frame_sched_if.slave bus
);

    localparam int c_P_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int c_CFG_W  = $clog2(CFG_WAIT + 1) > 0 ? $clog2(CFG_WAIT + 1) : 1;
    localparam int c_IDX_W  = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;
    localparam int c_COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int c_RUN_W  = $clog2(RUN_HOLD + 1) > 0 ? $clog2(RUN_HOLD + 1) : 1;
    localparam int c_PROD_W = GRAY_W + 8;
    localparam logic [OUT_W-1:0] c_FULL = OUT_W'(224 * 255);
    localparam logic [OUT_W-1:0] c_ONES = '1;

    logic [c_CFG_W-1:0] r_cfg_cnt;
    logic [c_P_W-1:0]   r_p;
    logic               r_pending;
    logic               r_sel;       // 0: buf0 active / buf1 shadow
    logic               r_swapped;   // first commit seen since reset
    logic               r_idx_err;
    logic [2:0]         r_mode;
    logic [7:0]         r_bright;
    logic [ADDR_W-1:0]  r_cursor;
    logic [c_RUN_W-1:0] r_run_cnt;
    logic [ADDR_W-1:0]  r_k;
    logic [c_COL_W-1:0] r_col;

    logic               r_s1_vld;
    logic [ADDR_W-1:0]  r_s1_addr;
    logic [c_COL_W-1:0] r_s1_col;
    logic [GRAY_W-1:0]  r_s1_gray;

    logic               r_wten;
    logic [ADDR_W-1:0]  r_wtaddr;
    logic [OUT_W-1:0]   r_wtdina;

    logic [GRAY_W-1:0]  r_buf0 [0:N_ZONES-1];
    logic [GRAY_W-1:0]  r_buf1 [0:N_ZONES-1];

    logic               w_cfg_done;
    logic               w_p_zero;
    logic               w_swap;
    logic               w_scan_issue;
    logic               w_idx_ok;
    logic [c_IDX_W-1:0] w_widx;
    logic [GRAY_W-1:0]  w_rd_gray;
    logic [7:0]         w_mult;
    logic [c_PROD_W-1:0] w_prod;
    logic [OUT_W-1:0]   w_data;

    assign w_cfg_done   = (32'(r_cfg_cnt) == CFG_WAIT);
    assign w_p_zero     = w_cfg_done && (r_p == '0);
    // A frame_done arriving exactly at p==0 commits immediately.
    assign w_swap       = w_p_zero && (r_pending || bus.frame_done);
    assign w_scan_issue = w_cfg_done && (32'(r_p) >= SCAN_START)
                          && (32'(r_p) < SCAN_START + N_ZONES);
    assign w_idx_ok     = (32'(bus.zone_idx) < N_ZONES);
    assign w_widx       = bus.zone_idx[c_IDX_W-1:0];
    assign w_rd_gray    = r_sel ? r_buf1[r_k[c_IDX_W-1:0]] : r_buf0[r_k[c_IDX_W-1:0]];

    // Buffer storage carries no reset; stale contents are masked by r_swapped.
    // A write in the commit cycle lands in the buffer that becomes active.
    always_ff @(posedge clk) begin
        if (bus.zone_valid && w_idx_ok) begin
            if (r_sel) begin
                r_buf0[w_widx] <= bus.zone_gray;
            end else begin
                r_buf1[w_widx] <= bus.zone_gray;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_cnt <= '0;
            r_p       <= '0;
            r_pending <= 1'b0;
            r_sel     <= 1'b0;
            r_swapped <= 1'b0;
            r_idx_err <= 1'b0;
            r_mode    <= '0;
            r_bright  <= '0;
            r_cursor  <= '0;
            r_run_cnt <= '0;
            r_k       <= '0;
            r_col     <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_addr <= '0;
            r_s1_col  <= '0;
            r_s1_gray <= '0;
            r_wten    <= 1'b0;
            r_wtaddr  <= '0;
            r_wtdina  <= '0;
        end else begin
            if (!w_cfg_done) begin
                r_cfg_cnt <= r_cfg_cnt + c_CFG_W'(1);
            end else begin
                r_p <= (32'(r_p) == PERIOD - 1) ? '0 : r_p + c_P_W'(1);
            end

            if (w_swap) begin
                r_sel     <= ~r_sel;
                r_swapped <= 1'b1;
                r_pending <= 1'b0;
            end else if (bus.frame_done) begin
                r_pending <= 1'b1;
            end

            if (bus.zone_valid && !w_idx_ok) begin
                r_idx_err <= 1'b1;
            end

            // Mode/brightness are latched once per period so a scan never tears.
            // The run counter starts at 0, so the cursor holds for the first
            // RUN_HOLD periods and then advances every RUN_HOLD periods.
            if (w_p_zero) begin
                r_mode   <= bus.mode;
                r_bright <= bus.bright;
                if (32'(r_run_cnt) == RUN_HOLD) begin
                    r_run_cnt <= c_RUN_W'(1);
                    r_cursor  <= (32'(r_cursor) == N_ZONES - 1) ? '0 : r_cursor + ADDR_W'(1);
                end else begin
                    r_run_cnt <= r_run_cnt + c_RUN_W'(1);
                end
            end

            // Zone index and column track the scan; column avoids a modulo.
            if (w_scan_issue) begin
                r_k   <= r_k + ADDR_W'(1);
                r_col <= (32'(r_col) == COLS - 1) ? '0 : r_col + c_COL_W'(1);
            end else begin
                r_k   <= '0;
                r_col <= '0;
            end

            // Stage 1: buffer read
            r_s1_vld  <= w_scan_issue;
            r_s1_addr <= w_scan_issue ? r_k : '0;
            r_s1_col  <= w_scan_issue ? r_col : '0;
            r_s1_gray <= (w_scan_issue && r_swapped) ? w_rd_gray : '0;

            // Stage 2: mode mapping and output register
            r_wten    <= r_s1_vld;
            r_wtaddr  <= r_s1_vld ? r_s1_addr : '0;
            r_wtdina  <= r_s1_vld ? w_data : '0;
        end
    end

    always_comb begin
        w_mult = (r_mode == 3'b010) ? r_bright : 8'd255;
        w_prod = c_PROD_W'(r_s1_gray) * c_PROD_W'(w_mult);
        w_data = '0;
        case (r_mode)
            3'b000:         w_data = c_FULL;
            3'b001:         w_data = (32'(r_s1_col) < COLS / 2) ? c_FULL : OUT_W'(w_prod);
            3'b010, 3'b011: w_data = OUT_W'(w_prod);
            3'b100:         w_data = (r_s1_addr == r_cursor) ? c_ONES : '0;
            default:        w_data = c_ONES;
        endcase
    end

    assign bus.sdbpflag   = w_cfg_done && (r_p != '0) && (32'(r_p) <= FLAG_LEN);
    assign bus.wten       = r_wten;
    assign bus.wtaddr     = r_wtaddr;
    assign bus.wtdina     = r_wtdina;
    assign bus.swap_pulse = w_swap;
    assign bus.idx_err    = r_idx_err && w_cfg_done;

endmodule
`default_nettype wire

// File: doc/backlight_frame_sched.md
BACKLIGHT_FRAME_SCHED -- requirements
Module: backlight_frame_sched

Interface
REQ-001 SHALL have parameter N_ZONES, default 360: number of backlight zones.
REQ-002 SHALL have parameter ADDR_W, default 10: zone-address width, with 2^ADDR_W >= N_ZONES.
REQ-003 SHALL have parameter GRAY_W, default 8: zone gray width.
REQ-004 SHALL have parameter OUT_W, default 16: driver data width, with OUT_W >= GRAY_W+8.
REQ-005 SHALL have parameter COLS, default 24: zones per row, used by split mode.
REQ-006 SHALL have parameter CFG_WAIT, default 2500: cycles after reset before any driver activity.
REQ-007 SHALL have parameter PERIOD, default 420000: refresh period in cycles, with PERIOD > SCAN_START+N_ZONES+3 and PERIOD > FLAG_LEN+1.
REQ-008 SHALL have parameter FLAG_LEN, default 30: length of the sdbpflag pulse in cycles.
REQ-009 SHALL have parameter SCAN_START, default 4: period count at which the zone scan starts.
REQ-010 SHALL have parameter RUN_HOLD, default 20: periods per running-light step.
REQ-011 clk  in  1  sole clock.
REQ-012 rst  in  1  reset, synchronous and active-high.
REQ-013 zone_valid  in  1  zone-write strobe.
REQ-014 zone_idx  in  ADDR_W  zone index of the write.
REQ-015 zone_gray  in  GRAY_W  gray value of the write.
REQ-016 frame_done  in  1  pulse: the shadow frame is complete.
REQ-017 mode  in  3  output mode select.
REQ-018 bright  in  8  global brightness.
REQ-019 sdbpflag  out  1  driver frame-start flag.
REQ-020 wten  out  1  write strobe, marks a valid driver word.
REQ-021 wtaddr  out  ADDR_W  driver address.
REQ-022 wtdina  out  OUT_W  driver data.
REQ-023 swap_pulse  out  1  one-cycle pulse when the buffers swap.
REQ-024 idx_err  out  1  sticky out-of-range-write flag.

Function
REQ-025 SHALL hold all outputs inactive (0) until the config counter reaches CFG_WAIT; cfg_done then rises and stays high until reset.
REQ-026 SHALL run period counter p from 0 to PERIOD-1 and wrap, counting only while cfg_done=1; p's first value after cfg_done rises is 0.
REQ-027 SHALL drive sdbpflag=1 exactly while p is in 1..FLAG_LEN, and 0 otherwise.
REQ-028 SHALL store zones in two N_ZONES x GRAY_W buffers (active and shadow); zone_valid writes zone_gray into shadow[zone_idx].
REQ-029 SHALL ignore a write with zone_idx >= N_ZONES and set idx_err=1; idx_err clears only on reset.
REQ-030 SHALL set a pending flag on frame_done; at p==0 with pending set, SHALL swap active and shadow, clear pending, and assert swap_pulse for that cycle.
REQ-031 frame_done coincident with p==0 SHALL swap in that same cycle.
REQ-032 A write coincident with frame_done SHALL be included in the committed frame.
REQ-033 A frame_done pulse while pending is already set SHALL be absorbed, with no second swap.
REQ-034 SHALL sample mode and bright only at p==0 and hold them for the whole period, so there is no mid-scan tearing.
REQ-035 Scan: for k = 0..N_ZONES-1, SHALL present wtaddr=k, its wtdina and wten=1 together at p = SCAN_START+k+2 (fixed 2-cycle read pipeline); all three SHALL be 0 outside the scan.
REQ-036 Data per mode, where g = active[k] and g=0 until the first swap after reset:
  - 000 full: 224*255 = 57120.
  - 001 split: (k mod COLS) < COLS/2 gives 57120; otherwise g*255.
  - 010 auto: g*bright.
  - 011 zone: g*255.
  - 100 running: all-ones on k==cursor, 0 elsewhere.
  - 101-111: all-ones.
REQ-037 Products SHALL be unsigned, zero-extended to OUT_W, with no saturation needed.
REQ-038 Running-light cursor SHALL advance by 1 every RUN_HOLD periods, at p==0, wrapping N_ZONES-1 to 0; it runs only while cfg_done=1, in any mode.

Reset
REQ-039 rst SHALL clear all counters, cfg_done, pending, buffer select, cursor, idx_err and every output to 0 in the next cycle, including mid-scan; buffer contents are undefined but masked per REQ-036.

Verification (N_ZONES=8, COLS=4, CFG_WAIT=5, PERIOD=40, FLAG_LEN=3, SCAN_START=4, RUN_HOLD=2)
REQ-040 Release reset, mode=000 -> no activity for 5 cycles; sdbpflag high at p=1..3; wten at p=6..13 with wtaddr 0..7 and wtdina=57120.
REQ-041 Write zone k gray 10*k+1, frame_done at p=20, mode=011 -> swap_pulse at the next p=0; that period outputs (10k+1)*255, and the previous period outputs 0.
REQ-042 mode=010, bright=128, gray 200 in all zones -> wtdina=25600; bright changed at p=7 -> no effect until the next period.
REQ-043 Write zone_idx=9 -> idx_err=1, no buffer change; frame_done at p=0 with a write in the same cycle -> immediate swap, write included.
REQ-044 mode=100 -> lit address 0,0,1,1,...,7,7,0 across successive periods; mode=001 -> zones 0,1,4,5 = 57120, others g*255.
REQ-045 Assert rst at p=8 mid-scan -> all outputs 0 the next cycle; restart repeats the REQ-040 timing.
